fetch_ifid_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register.
- Owns the PC and drives the instruction-memory address.
- Presents the raw fetched word to the NOP/stall detector. Consumes that detector's en_pc and NOPSrc to either hold the PC or inject bubbles into ID.
- Accepts a redirect (branch/jump target) from the resolving stage and flushes the wrong-path fetch.

---
 rtl/fetch_ifid_stage.sv | 71 +++++++
 tb/tb_fetch_ifid_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ifid_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, and holds the IF/ID
// pipeline register, with stall hold, bubble injection and redirect flush.
module fetch_ifid_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_pc,
    input  logic             nop_src,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr_if,
    output logic [31:0]      instr_id,
    output logic [31:0]      pc_plus4_id,
    output logic             valid_id,
    output logic [CNT_W-1:0] bubble_count,
    output logic             misalign_err
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;

    assign pc_plus4  = pc + 32'd4;
    assign flush     = redirect_valid | nop_src;
    assign imem_addr = pc;
    assign instr_if  = imem_rdata;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values; pc_plus4_id must see the PC from before this edge's update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc           <= PC_RESET;
            instr_id     <= NOP_WORD;
            pc_plus4_id  <= 32'd0;
            valid_id     <= 1'b0;
            bubble_count <= '0;
            misalign_err <= 1'b0;
        end else begin
            // A redirect wins over a stall: the target is taken even with en_pc low.
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (en_pc) begin
                pc <= pc_plus4;
            end

            // On a stall edge without nop_src the stalling instruction itself enters ID.
            if (flush) begin
                instr_id <= NOP_WORD;
                valid_id <= 1'b0;
            end else begin
                instr_id    <= imem_rdata;
                pc_plus4_id <= pc_plus4;
                valid_id    <= 1'b1;
            end

            if (flush && (bubble_count != {CNT_W{1'b1}})) begin
                bubble_count <= bubble_count + 1'b1;
            end

            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Self-checking bench for fetch_ifid_stage: a reference model pushes expected IF/ID state
// into a scoreboard queue when each edge's stimulus is driven; entries are popped after the edge.
module tb_fetch_ifid_stage;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam int          CNT_W    = 4;

    typedef struct {
        logic [31:0]      pc;
        logic [31:0]      instr;
        logic [31:0]      pc4;
        logic             valid;
        logic [CNT_W-1:0] bcnt;
        logic             mis;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en_pc = 1'b0;
    logic             nop_src = 1'b0;
    logic             redirect_valid = 1'b0;
    logic [31:0]      redirect_pc = 32'd0;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      instr_if;
    logic [31:0]      instr_id;
    logic [31:0]      pc_plus4_id;
    logic             valid_id;
    logic [CNT_W-1:0] bubble_count;
    logic             misalign_err;

    int tests_run = 0;
    int tests_failed = 0;

    exp_t sb[$];

    // Reference model state
    logic [31:0]      m_pc;
    logic [31:0]      m_instr;
    logic [31:0]      m_pc4;
    logic             m_valid;
    logic [CNT_W-1:0] m_bcnt;
    logic             m_mis;

    fetch_ifid_stage #(
        .PC_RESET (32'h0000_0000),
        .NOP_WORD (NOP_WORD),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en_pc          (en_pc),
        .nop_src        (nop_src),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .instr_if       (instr_if),
        .instr_id       (instr_id),
        .pc_plus4_id    (pc_plus4_id),
        .valid_id       (valid_id),
        .bubble_count   (bubble_count),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h1357_9BDF;
    endfunction

    // Combinational instruction memory
    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = NOP_WORD;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_bcnt  = '0;
        m_mis   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_addr"},  imem_addr, 32'h0);
        check({tag, "_instr"}, instr_id, NOP_WORD);
        check({tag, "_pc4"},   pc_plus4_id, 32'h0);
        check({tag, "_valid"}, {31'd0, valid_id}, 32'd0);
        check({tag, "_bcnt"},  {28'd0, bubble_count}, 32'd0);
        check({tag, "_mis"},   {31'd0, misalign_err}, 32'd0);
    endtask

    // Asserts reset mid-cycle (asynchronously), checks while held, releases away from an edge.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        sb.delete();
        check_reset_values({tag, "_async"});
        repeat (2) @(posedge clk);
        #1;
        check_reset_values({tag, "_held"});
        rst = 1'b1;
        #1;
    endtask

    // Drives one edge's inputs, pushes the model's expectation, then pops and compares after the edge.
    task automatic step(input logic en, input logic nop, input logic rv, input logic [31:0] rpc);
        exp_t e;
        logic [31:0] p4;
        en_pc          = en;
        nop_src        = nop;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        check("imem_addr", imem_addr, m_pc);
        check("instr_if", instr_if, mem_word(m_pc));

        p4 = m_pc + 32'd4;
        if (rv || nop) begin
            m_instr = NOP_WORD;
            m_valid = 1'b0;
            if (m_bcnt < 4'd15) m_bcnt = m_bcnt + 4'd1;
        end else begin
            m_instr = mem_word(m_pc);
            m_pc4   = p4;
            m_valid = 1'b1;
        end
        if (rv && rpc[1:0] != 2'b00) m_mis = 1'b1;
        if (rv) m_pc = {rpc[31:2], 2'b00};
        else if (en) m_pc = p4;
        e = '{pc: m_pc, instr: m_instr, pc4: m_pc4, valid: m_valid, bcnt: m_bcnt, mis: m_mis};
        sb.push_back(e);

        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("pc",       imem_addr, e.pc);
            check("instr_id", instr_id, e.instr);
            check("pc4_id",   pc_plus4_id, e.pc4);
            check("valid_id", {31'd0, valid_id}, {31'd0, e.valid});
            check("bcnt",     {28'd0, bubble_count}, {28'd0, e.bcnt});
            check("mis",      {31'd0, misalign_err}, {31'd0, e.mis});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset("rst0");

        // Sequential fetch, then reset in the middle of the run
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);
        check("seq_addr12", imem_addr, 32'h0000_000C);
        do_reset("rst_mid");
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("first_instr", instr_id, mem_word(32'h0));
        check("first_pc4", pc_plus4_id, 32'h4);
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);

        // Stall of 2 at PC=0x10
        check("stall_start", imem_addr, 32'h10);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("stall_word", instr_id, mem_word(32'h10));
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        check("stall_pc", imem_addr, 32'h10);
        check("stall_bcnt", {28'd0, bubble_count}, 32'd2);
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect during stall at PC=0x20
        check("redir_start", imem_addr, 32'h20);
        step(1'b0, 1'b1, 1'b1, 32'h400);
        check("redir_addr", imem_addr, 32'h400);
        check("redir_bcnt", {28'd0, bubble_count}, 32'd3);
        step(1'b1, 1'b0, 1'b0, 32'h0);

        // Misaligned redirect is sticky until reset
        step(1'b1, 1'b0, 1'b1, 32'h103);
        check("mis_pc", imem_addr, 32'h100);
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0);
        check("mis_sticky", {31'd0, misalign_err}, 32'd1);
        do_reset("rst_mis");

        // PC wrap and bubble-counter saturation
        step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc4", pc_plus4_id, 32'h0);
        repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0);
        check("bcnt_sat", {28'd0, bubble_count}, 32'h0000_000F);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
